unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
Shares one single-ported memory between instruction fetch (IF) and the load/store unit (D), one transaction outstanding at a time. Data side has priority, bounded by a starvation limit for IF. The block does byte-lane formatting for stores (wstrb, replicated data) and extracts and extends load data per mem_op_e, as produced by the decode stage's ctrl.mem_op. Misaligned accesses are rejected with an error response and never reach memory.

Parameters:
MAX_D_STREAK, 2, consecutive D grants allowed while IF is waiting before IF is forced (1..15)
TIMEOUT_CYCLES, 255, cycle limit for a memory transaction (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_req_valid  in  1  fetch request
if_req_addr  in  XLEN  fetch byte address
if_req_ready  out  1  fetch request accepted this cycle
if_rsp_valid  out  1  fetch response pulse
if_rsp_data  out  XLEN  fetched word
if_rsp_err  out  1  fetch misaligned/timeout
d_req_valid  in  1  data request
d_req_addr  in  XLEN  data byte address
d_req_we  in  1  1=store, 0=load
d_req_op  in  mem_op_e  access size/sign
d_req_wdata  in  XLEN  store data, right-aligned
d_req_ready  out  1  data request accepted this cycle
d_rsp_valid  out  1  data response pulse (loads and stores)
d_rsp_rdata  out  XLEN  extended load data; 0 for stores
d_rsp_err  out  1  data misaligned/timeout
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}
mem_we  out  1  write enable
mem_wstrb  out  4  byte enables
mem_wdata  out  XLEN  lane-formatted store data
mem_rsp_valid  in  1  memory response (reads and writes)
mem_rsp_rdata  in  XLEN  raw read word

Behaviour:
- Reset: every output 0, FSM=IDLE, streak=0. If reset is asserted mid-transaction, the transaction is abandoned, no response is issued, and the FSM is in IDLE the cycle after rst deasserts.
- FSM states: IDLE, REQ, WAIT_RSP, RESP, ERR.
- IDLE: combinationally assert if_req_ready or d_req_ready, never both. A handshake is valid&ready. Latch addr, we, op and wdata, and record the owner.
  - Aligned request: go to REQ.
  - Misaligned request: go to ERR. Misaligned means HALF/HALF_U with addr[0]=1, WORD with addr[1:0]!=0, or IF with addr[1:0]!=0.
- Arbitration in IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant D unless streak==MAX_D_STREAK, in which case grant IF.
  - streak increments (saturating) on a D grant while if_req_valid=1. It clears on an IF grant, or in IDLE when if_req_valid=0.
- REQ: mem_req_valid=1 with mem_addr, mem_we, mem_wstrb and mem_wdata stable. Hold until mem_req_ready=1, then go to WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, register the formatted data and go to RESP.
- RESP: the owner's rsp_valid=1 for exactly one cycle with err=0. Return to IDLE next cycle.
- ERR: the owner's rsp_valid=1 and err=1 with data 0 for one cycle. Return to IDLE. mem_req_valid is never asserted.
- Latency: handshake at cycle N gives mem_req_valid at N+1. With mem_req_ready at N+1 and mem_rsp_valid at N+2, rsp_valid is at N+3. The minimum turnaround is a new grant at N+4. Misaligned: err response at N+1.
- Store format: BYTE/BYTE_U gives wdata={4{b}} and wstrb=4'b0001<<addr[1:0]. HALF/HALF_U gives {2{h}} and 4'b0011<<{addr[1],1'b0}. WORD gives wdata unchanged and 4'b1111. Loads and IF use wstrb=0 and mem_we=0.
- Load format: shift = mem_rsp_rdata >> (8*addr[1:0]). BYTE/HALF sign-extend; BYTE_U/HALF_U zero-extend; WORD is passed through. IF data is the raw word.
- mem_rsp_valid arriving in IDLE or REQ is ignored.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter runs in REQ and WAIT_RSP and clears on entry to REQ. When it reaches TIMEOUT_CYCLES, go to ERR (err response to the owner) and drop mem_req_valid. A late mem_rsp_valid is ignored.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
1. Assert rst for 2 cycles mid-WAIT_RSP -> all outputs 0, no rsp_valid; a new request after reset completes normally.
2. D LB addr 0x1003, mem_rsp_rdata 0x80123456 -> mem_addr 0x1000, d_rsp_rdata 0xFFFFFF80. Same with LBU -> 0x00000080. d_rsp_valid arrives 3 cycles after the handshake with a zero-wait memory.
3. D SH addr 0x2002, wdata 0x0000BEEF -> mem_addr 0x2000, mem_wstrb 4'b1100, mem_wdata 0xBEEFBEEF, mem_we=1; d_rsp_valid with rdata 0.
4. IF and D valid continuously, MAX_D_STREAK=2 -> grant order D,D,I,D,D,I. With IF idle, D is granted every turnaround and streak stays 0.
5. D LW addr 0x1002 -> d_rsp_err=1 at handshake+1, mem_req_valid stays 0. IF addr 0x0006 behaves the same.
6. MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_req_ready held 0 -> err response after 8 cycles in REQ. The arbiter then accepts the next request.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter (plus package unified_mem_arbiter_pkg)
// Purpose  : Shares one single-ported memory between instruction fetch (IF)
//            and the load/store unit (D). Only one transaction is in flight at
//            a time. D has priority, but IF is forced through after
//            MAX_D_STREAK consecutive D grants made while IF was waiting.
//            Stores are lane-formatted (wstrb plus replicated data). Loads are
//            extracted and sign/zero-extended. Misaligned requests get an
//            error response and never reach memory.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            if_req_* / if_rsp_* - fetch request/response
//            d_req_*  / d_rsp_*  - load/store request/response
//            mem_req_* / mem_*   - memory request channel
//            mem_rsp_*           - memory response channel
// Options  : MEM_TIMEOUT_EN - when defined, a transaction that stays in
//            REQ/WAIT_RSP for TIMEOUT_CYCLES cycles ends with an error response.
// Revision : 1.0 - initial release
// ============================================================================

package unified_mem_arbiter_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_BYTE   = 3'd0,
    OP_HALF   = 3'd1,
    OP_WORD   = 3'd2,
    OP_BYTE_U = 3'd4,
    OP_HALF_U = 3'd5
  } mem_op_e;
endpackage

module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_req_ready,
  output logic            if_rsp_valid,
  output logic [XLEN-1:0] if_rsp_data,
  output logic            if_rsp_err,
  input  logic            d_req_valid,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic            d_req_we,
  input  mem_op_e         d_req_op,
  input  logic [XLEN-1:0] d_req_wdata,
  output logic            d_req_ready,
  output logic            d_rsp_valid,
  output logic [XLEN-1:0] d_rsp_rdata,
  output logic            d_rsp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_REQ      = 3'd1;
  localparam logic [2:0] c_WAIT_RSP = 3'd2;
  localparam logic [2:0] c_RESP     = 3'd3;
  localparam logic [2:0] c_ERR      = 3'd4;

  localparam logic [3:0] c_STREAK_LIMIT = 4'(MAX_D_STREAK);

  logic [2:0]      state_q, state_d;
  logic            owner_d_q, owner_d_d;   // 1: D owns the transaction, 0: IF
  logic [XLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  mem_op_e         op_q, op_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [3:0]      streak_q, streak_d;

  logic            w_grant_d;
  logic            w_grant_if;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_fmt;
  logic            w_timeout;

  // Alignment rule shared by D and IF (IF is always a word access).
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] a);
    logic r;
    case (op)
      OP_BYTE, OP_BYTE_U: r = 1'b0;
      OP_HALF, OP_HALF_U: r = a[0];
      default:            r = (a != 2'b00);
    endcase
    return r;
  endfunction

  // D wins unless IF is also waiting and D has already used its streak.
  assign w_grant_d  = d_req_valid && !(if_req_valid && (streak_q == c_STREAK_LIMIT));
  assign w_grant_if = if_req_valid && !w_grant_d;

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign w_shifted = mem_rsp_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    w_load_fmt = mem_rsp_rdata;
    if (we_q) begin
      w_load_fmt = '0;
    end else if (owner_d_q) begin
      case (op_q)
        OP_BYTE:   w_load_fmt = {{24{w_shifted[7]}}, w_shifted[7:0]};
        OP_BYTE_U: w_load_fmt = {24'b0, w_shifted[7:0]};
        OP_HALF:   w_load_fmt = {{16{w_shifted[15]}}, w_shifted[15:0]};
        OP_HALF_U: w_load_fmt = {16'b0, w_shifted[15:0]};
        default:   w_load_fmt = mem_rsp_rdata;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_TW-1:0] tmo_q, tmo_d;

  // The counter is 0 on the first REQ cycle, so reaching TIMEOUT_CYCLES-1
  // means this is the TIMEOUT_CYCLES-th cycle spent waiting.
  assign w_timeout = (tmo_q == c_TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if ((state_q == c_REQ) || (state_q == c_WAIT_RSP)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout          = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_IDLE;
      owner_d_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      op_q      <= OP_BYTE;
      wdata_q   <= '0;
      rdata_q   <= '0;
      streak_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      streak_q  <= streak_d;
    end
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    addr_d    = addr_q;
    we_d      = we_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    streak_d  = streak_q;

    case (state_q)
      c_IDLE: begin
        if (w_grant_if || !if_req_valid) begin
          streak_d = '0;
        end else if (w_grant_d && (streak_q != 4'hF)) begin
          streak_d = streak_q + 4'd1;
        end

        if (w_grant_d) begin
          owner_d_d = 1'b1;
          addr_d    = d_req_addr;
          we_d      = d_req_we;
          op_d      = d_req_op;
          wdata_d   = d_req_wdata;
          state_d   = is_misaligned(d_req_op, d_req_addr[1:0]) ? c_ERR : c_REQ;
        end else if (w_grant_if) begin
          owner_d_d = 1'b0;
          addr_d    = if_req_addr;
          we_d      = 1'b0;
          op_d      = OP_WORD;
          wdata_d   = '0;
          state_d   = is_misaligned(OP_WORD, if_req_addr[1:0]) ? c_ERR : c_REQ;
        end
      end
      // An accepted request always proceeds even if the timeout hits on the
      // same cycle: memory has already committed to it.
      c_REQ: begin
        if (mem_req_ready) begin
          state_d = c_WAIT_RSP;
        end else if (w_timeout) begin
          state_d = c_ERR;
        end
      end
      c_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rdata_d = w_load_fmt;
          state_d = c_RESP;
        end else if (w_timeout) begin
          state_d = c_ERR;
        end
      end
      c_RESP:  state_d = c_IDLE;
      c_ERR:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Outputs. Everything is held at 0 while rst is high so that a mid-flight
  // reset shows a quiet interface immediately.
  always_comb begin
    if_req_ready  = 1'b0;
    d_req_ready   = 1'b0;
    if_rsp_valid  = 1'b0;
    if_rsp_data   = '0;
    if_rsp_err    = 1'b0;
    d_rsp_valid   = 1'b0;
    d_rsp_rdata   = '0;
    d_rsp_err     = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wstrb     = 4'b0000;
    mem_wdata     = '0;

    if (!rst) begin
      if (state_q == c_IDLE) begin
        if_req_ready = w_grant_if;
        d_req_ready  = w_grant_d;
      end

      if (state_q == c_REQ) begin
        mem_req_valid = 1'b1;
        mem_addr      = {addr_q[XLEN-1:2], 2'b00};
        mem_we        = we_q;
        if (we_q) begin
          case (op_q)
            OP_BYTE, OP_BYTE_U: begin
              mem_wdata = {4{wdata_q[7:0]}};
              mem_wstrb = 4'b0001 << addr_q[1:0];
            end
            OP_HALF, OP_HALF_U: begin
              mem_wdata = {2{wdata_q[15:0]}};
              mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
              mem_wdata = wdata_q;
              mem_wstrb = 4'b1111;
            end
          endcase
        end
      end

      if ((state_q == c_RESP) || (state_q == c_ERR)) begin
        if (owner_d_q) begin
          d_rsp_valid = 1'b1;
          d_rsp_err   = (state_q == c_ERR);
          d_rsp_rdata = (state_q == c_RESP) ? rdata_q : '0;
        end else begin
          if_rsp_valid = 1'b1;
          if_rsp_err   = (state_q == c_ERR);
          if_rsp_data  = (state_q == c_RESP) ? rdata_q : '0;
        end
      end
    end
  end

endmodule

`default_nettype wire
